// File: rtl/axi4s_s2m_nm_router.sv
// axi4s_s2m_nm_router: TID-decoded AXI4-Stream 1-to-N packet router with drop/default handling
module axi4s_s2m_nm_router #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_STRB_WIDTH_P = 4,
  parameter int AXI_KEEP_WIDTH_P = 4,
  parameter int AXI_ID_WIDTH_P = 4,
  parameter int AXI_DEST_WIDTH_P = 4,
  parameter int AXI_USER_WIDTH_P = 1,
  parameter int NR_OF_MASTERS_P = 4,
  parameter logic [NR_OF_MASTERS_P*AXI_ID_WIDTH_P-1:0] MASTER_TIDS_P = '0,
  parameter bit DROP_UNMATCHED_P = 1'b1,
  parameter int DROP_CNT_WIDTH_P = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic slv_tvalid,
  output logic slv_tready,
  input  logic [AXI_DATA_WIDTH_P-1:0] slv_tdata,
  input  logic [AXI_STRB_WIDTH_P-1:0] slv_tstrb,
  input  logic [AXI_KEEP_WIDTH_P-1:0] slv_tkeep,
  input  logic slv_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0] slv_tid,
  input  logic [AXI_DEST_WIDTH_P-1:0] slv_tdest,
  input  logic [AXI_USER_WIDTH_P-1:0] slv_tuser,
  output logic [NR_OF_MASTERS_P-1:0] mst_tvalid,
  input  logic [NR_OF_MASTERS_P-1:0] mst_tready,
  output logic [NR_OF_MASTERS_P*AXI_DATA_WIDTH_P-1:0] mst_tdata,
  output logic [NR_OF_MASTERS_P*AXI_STRB_WIDTH_P-1:0] mst_tstrb,
  output logic [NR_OF_MASTERS_P*AXI_KEEP_WIDTH_P-1:0] mst_tkeep,
  output logic [NR_OF_MASTERS_P-1:0] mst_tlast,
  output logic [NR_OF_MASTERS_P*AXI_ID_WIDTH_P-1:0] mst_tid,
  output logic [NR_OF_MASTERS_P*AXI_DEST_WIDTH_P-1:0] mst_tdest,
  output logic [NR_OF_MASTERS_P*AXI_USER_WIDTH_P-1:0] mst_tuser,
  output logic sts_busy,
  output logic [3:0] sts_selected,
  output logic [DROP_CNT_WIDTH_P-1:0] sts_drop_count
);
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;
  state_t state;
  logic [3:0] sel;
  logic [3:0] hit_idx;
  logic hit;
  logic route;
  logic done;
  logic [NR_OF_MASTERS_P-1:0] sel_oh;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NR_OF_MASTERS_P - 1; i >= 0; i--)
      if (slv_tid == MASTER_TIDS_P[i*AXI_ID_WIDTH_P +: AXI_ID_WIDTH_P]) begin
        hit = 1'b1;
        hit_idx = 4'(i);
      end
  end
  assign route = state == ROUTE;
  assign done = slv_tvalid && slv_tready && slv_tlast;
  assign slv_tready = route ? |(mst_tready & sel_oh) : state == DROP;
  assign sts_busy = state != IDLE;
  assign sts_selected = route ? sel : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      sts_drop_count <= '0;
    end else
      case (state)
        IDLE: if (slv_tvalid) begin
          state <= (hit || !DROP_UNMATCHED_P) ? ROUTE : DROP;
          sel <= hit ? hit_idx : '0;
        end
        ROUTE: if (done) state <= IDLE;
        default: if (done) begin
          state <= IDLE;
          if (sts_drop_count != '1) sts_drop_count <= sts_drop_count + DROP_CNT_WIDTH_P'(1);
        end
      endcase
  genvar g;
  for (g = 0; g < NR_OF_MASTERS_P; g++) begin : g_mst
    assign sel_oh[g] = route && sel == 4'(g);
    assign mst_tvalid[g] = sel_oh[g] && slv_tvalid;
    assign mst_tlast[g] = sel_oh[g] && slv_tlast;
    assign mst_tdata[g*AXI_DATA_WIDTH_P +: AXI_DATA_WIDTH_P] = sel_oh[g] ? slv_tdata : '0;
    assign mst_tstrb[g*AXI_STRB_WIDTH_P +: AXI_STRB_WIDTH_P] = sel_oh[g] ? slv_tstrb : '0;
    assign mst_tkeep[g*AXI_KEEP_WIDTH_P +: AXI_KEEP_WIDTH_P] = sel_oh[g] ? slv_tkeep : '0;
    assign mst_tid[g*AXI_ID_WIDTH_P +: AXI_ID_WIDTH_P] = sel_oh[g] ? slv_tid : '0;
    assign mst_tdest[g*AXI_DEST_WIDTH_P +: AXI_DEST_WIDTH_P] = sel_oh[g] ? slv_tdest : '0;
    assign mst_tuser[g*AXI_USER_WIDTH_P +: AXI_USER_WIDTH_P] = sel_oh[g] ? slv_tuser : '0;
  end
endmodule

// File: tb/tb_axi4s_s2m_nm_router.sv
// tb_axi4s_s2m_nm_router: directed and random packets against a per-beat routing model, both drop modes
module tb_axi4s_s2m_nm_router;
  localparam int N = 4, DW = 32, SW = 4, KW = 4, IW = 4, TW = 4, UW = 1, CW = 4;
  localparam logic [N*IW-1:0] TIDS = {4'd9, 4'd7, 4'd5, 4'd3};
  int tid_of [N] = '{3, 5, 7, 9};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;
  logic [KW-1:0] s_keep = '0;
  logic [IW-1:0] s_tid = '0;
  logic [TW-1:0] s_dest = '0;
  logic [UW-1:0] s_user = '0;
  logic [N-1:0] m_ready = '1;
  logic s_rdy [2];
  logic [N-1:0] m_vld [2];
  logic [N-1:0] m_lst [2];
  logic [N*DW-1:0] m_dat [2];
  logic [N*SW-1:0] m_stb [2];
  logic [N*KW-1:0] m_kep [2];
  logic [N*IW-1:0] m_id [2];
  logic [N*TW-1:0] m_dst [2];
  logic [N*UW-1:0] m_usr [2];
  logic busy [2];
  logic [3:0] seld [2];
  logic [CW-1:0] dcnt [2];
  int md = 1;
  int drops = 0;
  int n_cmp = 0, n_bad = 0;
  for (genvar d = 0; d < 2; d++) begin : g_dut
    axi4s_s2m_nm_router #(
      .AXI_DATA_WIDTH_P(DW), .AXI_STRB_WIDTH_P(SW), .AXI_KEEP_WIDTH_P(KW),
      .AXI_ID_WIDTH_P(IW), .AXI_DEST_WIDTH_P(TW), .AXI_USER_WIDTH_P(UW),
      .NR_OF_MASTERS_P(N), .MASTER_TIDS_P(TIDS), .DROP_UNMATCHED_P(1'(d)),
      .DROP_CNT_WIDTH_P(CW)
    ) dut (
      .clk(clk), .rst(rst),
      .slv_tvalid(s_valid), .slv_tready(s_rdy[d]), .slv_tdata(s_data), .slv_tstrb(s_strb),
      .slv_tkeep(s_keep), .slv_tlast(s_last), .slv_tid(s_tid), .slv_tdest(s_dest), .slv_tuser(s_user),
      .mst_tvalid(m_vld[d]), .mst_tready(m_ready), .mst_tdata(m_dat[d]), .mst_tstrb(m_stb[d]),
      .mst_tkeep(m_kep[d]), .mst_tlast(m_lst[d]), .mst_tid(m_id[d]), .mst_tdest(m_dst[d]),
      .mst_tuser(m_usr[d]),
      .sts_busy(busy[d]), .sts_selected(seld[d]), .sts_drop_count(dcnt[d])
    );
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // Lowest master whose TID matches; -1 means the packet is discarded.
  function automatic int exp_dest(input int tid);
    for (int i = 0; i < N; i++) if (tid_of[i] == tid) return i;
    return md ? -1 : 0;
  endfunction
  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = '1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", busy[md], 0);
    chk("rst_vld", m_vld[md], 0);
    chk("rst_rdy", s_rdy[md], 0);
    chk("rst_sel", seld[md], 0);
    chk("rst_cnt", dcnt[md], 0);
    chk("rst_data", m_dat[md], 0);
    @(posedge clk); #1;
    rst = 1'b0; drops = 0;
  endtask
  task automatic run_pkt(input int tid, input int tid2, input int nb, input logic [DW-1:0] d0,
                         input int stall, input bit rnd, input int abort_at);
    logic [DW-1:0] dat [8];
    logic [12:0] sd [8];
    int k, b, c;
    bit hs;
    k = exp_dest(tid);
    for (int i = 0; i < nb; i++) begin
      dat[i] = (i == 0) ? d0 : DW'($urandom);
      sd[i] = 13'($urandom);
    end
    b = 0; c = 0;
    while (b < nb) begin
      s_valid = 1'b1; s_tid = IW'(b > 0 ? tid2 : tid); s_data = dat[b];
      {s_user, s_dest, s_keep, s_strb} = sd[b]; s_last = (b == nb - 1);
      m_ready = rnd ? N'($urandom) : ((c >= 1 && c <= stall && k >= 0) ? ~(4'b1 << k) : 4'hF);
      @(negedge clk);
      if (c == 0) begin
        hs = 1'b0;
        chk("idle_vld", m_vld[md], 0);
        chk("idle_rdy", s_rdy[md], 0);
        chk("idle_busy", busy[md], 0);
      end else if (k >= 0) begin
        hs = m_ready[k];
        chk("rt_vld", m_vld[md], 4'b1 << k);
        chk("rt_rdy", s_rdy[md], hs);
        chk("rt_data", m_dat[md], 128'(dat[b]) << (k * DW));
        chk("rt_tid", m_id[md], 16'(s_tid) << (k * IW));
        chk("rt_last", m_lst[md], 4'(s_last) << k);
        chk("rt_side", {m_stb[md], m_kep[md], m_dst[md], m_usr[md]},
            {16'(sd[b][3:0]) << (k * 4), 16'(sd[b][7:4]) << (k * 4),
             16'(sd[b][11:8]) << (k * 4), 4'(sd[b][12]) << k});
        chk("rt_sel", seld[md], k);
        chk("rt_busy", busy[md], 1);
      end else begin
        hs = 1'b1;
        chk("dr_vld", m_vld[md], 0);
        chk("dr_rdy", s_rdy[md], 1);
        chk("dr_data", m_dat[md], 0);
        chk("dr_sel", seld[md], 0);
        chk("dr_busy", busy[md], 1);
      end
      @(posedge clk); #1;
      c++;
      if (hs) b++;
      if (hs && b == abort_at && b < nb) begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; drops = 0;
        @(negedge clk);
        chk("ab_vld", m_vld[md], 0);
        chk("ab_rdy", s_rdy[md], 0);
        chk("ab_busy", busy[md], 0);
        chk("ab_sel", seld[md], 0);
        chk("ab_data", m_dat[md], 0);
        chk("ab_cnt", dcnt[md], 0);
        @(posedge clk); #1;
        return;
      end
      if (c > 100) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = '1;
    if (k < 0) drops++;
    @(negedge clk);
    chk("post_busy", busy[md], 0);
    chk("post_vld", m_vld[md], 0);
    chk("post_rdy", s_rdy[md], 0);
    chk("drop_cnt", dcnt[md], drops > 15 ? 15 : drops);
    @(posedge clk); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int t;
    md = 1;
    do_reset();
    run_pkt(5, 5, 1, 32'hA5A5A5A5, 0, 1'b0, 0);
    run_pkt(9, 3, 3, DW'($urandom), 2, 1'b0, 0);
    run_pkt(4, 4, 2, DW'($urandom), 0, 1'b0, 0);
    md = 0;
    do_reset();
    run_pkt(4, 4, 2, DW'($urandom), 0, 1'b0, 0);
    md = 1;
    do_reset();
    repeat (17) run_pkt(int'($urandom_range(10, 15)), 0, 1, DW'($urandom), 0, 1'b0, 0);
    do_reset();
    run_pkt(7, 7, 3, DW'($urandom), 0, 1'b0, 1);
    run_pkt(3, 3, 2, DW'($urandom), 0, 1'b0, 0);
    for (int m = 0; m < 2; m++) begin
      md = m;
      do_reset();
      for (int p = 0; p < 40; p++) begin
        t = $urandom_range(0, 1) ? tid_of[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
        run_pkt(t, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), DW'($urandom), 0, 1'b1, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4s_s2m_nm_router.md
AXI4S_S2M_NM_ROUTER -- requirements
Module: axi4s_s2m_nm_router

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- AXI_DATA_WIDTH_P, 32, tdata width
- AXI_STRB_WIDTH_P, 4, tstrb width
- AXI_KEEP_WIDTH_P, 4, tkeep width
- AXI_ID_WIDTH_P, 4, tid width
- AXI_DEST_WIDTH_P, 4, tdest width
- AXI_USER_WIDTH_P, 1, tuser width
- NR_OF_MASTERS_P, 4, egress port count, legal 2..16
- MASTER_TIDS_P, 0, packed NR_OF_MASTERS_P*AXI_ID_WIDTH_P vector; slice k is master k's TID
- DROP_UNMATCHED_P, 1, 1 = discard unmatched packets; 0 = route them to master 0
- DROP_CNT_WIDTH_P, 16, drop counter width
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- slv_tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser  in (tready out)  per width  ingress AXI4-S
- mst_tvalid  out  N  per-master valid; mst_tready  in  N
- mst_tdata/tstrb/tkeep/tid/tdest/tuser  out  N*width  packed; slice k belongs to master k
- mst_tlast  out  N
- sts_busy  out  1  high when state is not IDLE
- sts_selected  out  4  index of latched master; 0 when IDLE
- sts_drop_count  out  DROP_CNT_WIDTH_P  saturating dropped-packet count

Function
REQ-003 SHALL implement states IDLE, ROUTE and DROP.
REQ-004 IDLE: slv_tready=0; all mst_tvalid=0. When slv_tvalid=1, SHALL compare slv_tid with every MASTER_TIDS_P slice and register the result.
REQ-005 On a match, SHALL latch the lowest matching index k and go to ROUTE. Duplicate TIDs resolve to the lowest index.
REQ-006 On no match, SHALL go to DROP if DROP_UNMATCHED_P=1. If DROP_UNMATCHED_P=0, SHALL latch k=0 and go to ROUTE.
REQ-007 ROUTE: SHALL connect the ingress combinationally to master k, with zero-cycle latency.
- mst_tvalid[k]=slv_tvalid; slv_tready=mst_tready[k]; all slice-k payload fields equal the ingress fields.
- Every other master's tvalid and payload fields SHALL be 0.
REQ-008 DROP: slv_tready=1; all mst_tvalid=0; all payload outputs 0.
REQ-009 ROUTE and DROP SHALL return to IDLE on the cycle after the handshake slv_tvalid&&slv_tready&&slv_tlast.
REQ-010 A single-beat packet (tlast on the first beat) SHALL take IDLE->ROUTE/DROP->IDLE.
REQ-011 Every packet SHALL cost exactly one IDLE decode cycle. Back-to-back packets have one bubble between them.
REQ-012 A slv_tid change mid-packet SHALL NOT change k. Routing is fixed until tlast.
REQ-013 The router SHALL NOT drop or reorder beats in ROUTE. A beat stalled by mst_tready=0 SHALL stay presented, with valid held and ingress stable per AXI4-S.
REQ-014 sts_drop_count SHALL increment by 1 on each DROP-state tlast handshake and SHALL saturate at all-ones.
REQ-015 sts_selected SHALL equal k in ROUTE, 0 in DROP and 0 in IDLE.

Reset
REQ-016 While rst=1 at a rising clk edge, the block SHALL enter IDLE and clear k and sts_drop_count.
REQ-017 Outputs SHALL be 0 from the first cycle after reset: slv_tready, all mst_* outputs, sts_busy, sts_selected.
REQ-018 Reset mid-packet SHALL abandon the packet with no completion. The next decode starts from the first slv_tvalid after rst deasserts.

Verification
REQ-019 Every bench configuration SHALL use NR_OF_MASTERS_P=4, MASTER_TIDS_P={9,7,5,3} (master0=3, master3=9), DROP_CNT_WIDTH_P=4. The bench SHALL cover these scenarios:
- Single beat, tid=5, tdata=0xA5A5A5A5, all tready=1 -> mst_tvalid=4'b0010 one cycle after slv_tvalid; slice1 tdata=0xA5A5A5A5; back to IDLE next cycle.
- 3-beat packet, tid=9, mst_tready[3]=0 for 2 cycles, tid switched to 3 on beat 2 -> slv_tready=0 during the stall; all 3 beats reach master 3 in order; master 0 valid stays 0.
- 2-beat packet, tid=4, DROP_UNMATCHED_P=1 -> slv_tready=1 for 2 cycles; all mst_tvalid=0; sts_drop_count=1.
- Same 2-beat tid=4 packet with DROP_UNMATCHED_P=0 -> delivered on master 0; sts_drop_count=0.
- 17 unmatched single-beat packets -> sts_drop_count=15, saturated.
- Same packet config as the second scenario, tid=7, rst=1 after beat 1 -> next cycle all outputs 0, state IDLE; a following tid=3 packet is routed to master 0.
